// File: rtl/cc_eval_if.sv
// Handshake and data bundle between an ALU result producer, cc_eval_unit and
// the consumer of the evaluated condition.
interface cc_eval_if #(
   parameter int WIDTH = 64
) ();
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       alu_fun;
   logic [WIDTH-1:0] alu_out;
   logic             alu_of;
   logic             set_cc;
   logic [3:0]       ifun;
   logic             cnd_valid;
   logic             cnd_ready;
   logic             cnd;
   logic [2:0]       cc;
   logic             err;

   modport master (
      output in_valid, alu_fun, alu_out, alu_of, set_cc, ifun, cnd_ready,
      input  in_ready, cnd_valid, cnd, cc, err
   );

   modport slave (
      input  in_valid, alu_fun, alu_out, alu_of, set_cc, ifun, cnd_ready,
      output in_ready, cnd_valid, cnd, cc, err
   );
endinterface

// File: rtl/cc_eval_unit.sv
// Condition-code register plus branch/cmov condition evaluator with a single-entry
// output register. Optional macro CC_EVAL_BYPASS_EN evaluates against a beat's own new flags.
module cc_eval_unit #(
   parameter int WIDTH = 64
) (
   input logic    clk,
   input logic    rst,
   cc_eval_if.slave bus
);
   localparam logic [2:0] CC_RESET = 3'b100;

   logic [2:0] cc_r;
   logic       cnd_r;
   logic       cnd_valid_r;
   logic       err_r;

   logic       in_ready_s;
   logic       accept_s;
   logic [2:0] new_flags_s;
   logic [2:0] eval_flags_s;
   logic [1:0] cond_s;

   // Returns {illegal, cnd}; flags are ordered {ZF,SF,OF}.
   function automatic logic [1:0] eval_cond(input logic [3:0] code, input logic [2:0] flags);
      logic lt;
      lt = flags[1] ^ flags[0];
      case (code)
         4'd0:    eval_cond = 2'b01;
         4'd1:    eval_cond = {1'b0, lt | flags[2]};
         4'd2:    eval_cond = {1'b0, lt};
         4'd3:    eval_cond = {1'b0, flags[2]};
         4'd4:    eval_cond = {1'b0, ~flags[2]};
         4'd5:    eval_cond = {1'b0, ~lt};
         4'd6:    eval_cond = {1'b0, ~lt & ~flags[2]};
         default: eval_cond = 2'b10;
      endcase
   endfunction

   assign in_ready_s = ~cnd_valid_r | bus.cnd_ready;
   assign accept_s   = bus.in_valid & in_ready_s;

   // Flags produced by the incoming beat; logic ops never overflow.
   always_comb begin
      new_flags_s[2] = (bus.alu_out == {WIDTH{1'b0}});
      new_flags_s[1] = bus.alu_out[WIDTH-1];
      if (bus.alu_fun[1] == 1'b0) begin
         new_flags_s[0] = bus.alu_of;
      end else begin
         new_flags_s[0] = 1'b0;
      end
   end

   // Select which flag set the condition is evaluated against.
   always_comb begin
`ifdef CC_EVAL_BYPASS_EN
      if (bus.set_cc) begin
         eval_flags_s = new_flags_s;
      end else begin
         eval_flags_s = cc_r;
      end
`else
      eval_flags_s = cc_r;
`endif
      cond_s = eval_cond(bus.ifun, eval_flags_s);
   end

   // Flag register, output register and sticky error; a consume with a
   // simultaneous accept simply overwrites the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cc_r        <= CC_RESET;
         cnd_r       <= 1'b0;
         cnd_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else if (accept_s) begin
         cnd_r       <= cond_s[0];
         cnd_valid_r <= 1'b1;
         if (bus.set_cc) begin
            cc_r <= new_flags_s;
         end
         if (cond_s[1]) begin
            err_r <= 1'b1;
         end
      end else if (bus.cnd_ready) begin
         cnd_valid_r <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.cnd_valid = cnd_valid_r;
   assign bus.cnd       = cnd_r;
   assign bus.cc        = cc_r;
   assign bus.err       = err_r;
endmodule

// File: tb/tb_cc_eval_unit.sv
// Table-driven, scoreboarded bench for cc_eval_unit (WIDTH=64), plus backpressure
// and reset sequences. Expected columns cover both CC_EVAL_BYPASS_EN builds.
module tb_cc_eval_unit;
   logic clk = 1'b0;
   logic rst;

   cc_eval_if #(.WIDTH(64)) bus ();

   cc_eval_unit #(.WIDTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       cnd;
      logic [2:0] cc;
      logic       err;
   } exp_t;

   typedef struct {
      logic [1:0]  fun;
      logic [63:0] out;
      logic        ovf;
      logic        set;
      logic [3:0]  ifn;
      logic        cnd_nb;
      logic        cnd_bp;
      logic [2:0]  cc;
      logic        err;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   exp_t mon_e;
   vec_t tbl[15];
   exp_t e_tmp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Present a beat and hold it until accepted; optionally queue its expected result.
   task automatic drive_beat(input logic [1:0] fun, input logic [63:0] out, input logic ovf,
                             input logic set, input logic [3:0] ifn,
                             input logic do_push, input exp_t e);
      bit done;
      bus.alu_fun  = fun;
      bus.alu_out  = out;
      bus.alu_of   = ovf;
      bus.set_cc   = set;
      bus.ifun     = ifn;
      bus.in_valid = 1'b1;
      if (do_push) q.push_back(e);
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready stayed 0, want 1");
      end
   endtask

   // Scoreboard: compare each result in the cycle the consumer takes it.
   always @(negedge clk) begin
      if (!rst && bus.cnd_valid && bus.cnd_ready) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: got cnd=%0d cc=%b err=%0d, want no result",
                     bus.cnd, bus.cc, bus.err);
         end else begin
            mon_e = q.pop_front();
            if ({bus.cnd, bus.cc, bus.err} !== mon_e) begin
               bad++;
               $display("FAIL result: got cnd=%0d cc=%b err=%0d, want cnd=%0d cc=%b err=%0d",
                        bus.cnd, bus.cc, bus.err, mon_e.cnd, mon_e.cc, mon_e.err);
            end
         end
      end
   end

   initial begin
      //          fun    alu_out                   ovf   set   ifun  nb    bp    cc      err
      tbl[0]  = '{2'd0, 64'd138922938,             1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 3'b000, 1'b0};
      tbl[1]  = '{2'd0, 64'h8000_0000_0000_0000,   1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 3'b011, 1'b0};
      tbl[2]  = '{2'd1, 64'd5,                     1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 3'b011, 1'b0};
      tbl[3]  = '{2'd3, 64'd0,                     1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 3'b100, 1'b0};
      tbl[4]  = '{2'd2, 64'd7,                     1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 3'b100, 1'b0};
      tbl[5]  = '{2'd0, 64'd1,                     1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 3'b100, 1'b0};
      tbl[6]  = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF,   1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 3'b010, 1'b0};
      tbl[7]  = '{2'd0, 64'd3,                     1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 3'b010, 1'b0};
      tbl[8]  = '{2'd0, 64'd3,                     1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 3'b010, 1'b0};
      tbl[9]  = '{2'd1, 64'h7FFF_FFFF_FFFF_FFFF,   1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 3'b001, 1'b0};
      tbl[10] = '{2'd2, 64'd2,                     1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 3'b000, 1'b0};
      tbl[11] = '{2'd0, 64'd2,                     1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 3'b000, 1'b0};
      tbl[12] = '{2'd0, 64'd0,                     1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 3'b000, 1'b1};
      tbl[13] = '{2'd0, 64'd0,                     1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 3'b000, 1'b1};
      tbl[14] = '{2'd0, 64'd0,                     1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 3'b000, 1'b1};

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.alu_fun = 2'd0; bus.alu_out = 64'd0; bus.alu_of = 1'b0;
      bus.set_cc = 1'b0; bus.ifun = 4'd0; bus.cnd_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_cc", {61'd0, bus.cc}, 64'd4);
      chk("reset_cnd_valid", {63'd0, bus.cnd_valid}, 64'd0);
      chk("reset_err", {63'd0, bus.err}, 64'd0);
      chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Back-to-back beats at full throughput.
      for (int i = 0; i < 15; i++) begin
`ifdef CC_EVAL_BYPASS_EN
         e_tmp = '{cnd: tbl[i].cnd_bp, cc: tbl[i].cc, err: tbl[i].err};
`else
         e_tmp = '{cnd: tbl[i].cnd_nb, cc: tbl[i].cc, err: tbl[i].err};
`endif
         drive_beat(tbl[i].fun, tbl[i].out, tbl[i].ovf, tbl[i].set, tbl[i].ifn, 1'b1, e_tmp);
      end
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: the held result must not move and stalled inputs are ignored.
      bus.cnd_ready = 1'b0;
      drive_beat(2'd0, 64'h10, 1'b0, 1'b1, 4'd4, 1'b1, '{cnd: 1'b1, cc: 3'b000, err: 1'b1});
      bus.alu_fun = 2'd2; bus.alu_out = 64'd0; bus.set_cc = 1'b1; bus.ifun = 4'd3;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
         chk("stall_cnd_valid", {63'd0, bus.cnd_valid}, 64'd1);
         chk("stall_cnd", {63'd0, bus.cnd}, 64'd1);
         chk("stall_cc", {61'd0, bus.cc}, 64'd0);
         @(posedge clk);
         #1;
      end
      bus.cnd_ready = 1'b1;
`ifdef CC_EVAL_BYPASS_EN
      e_tmp = '{cnd: 1'b1, cc: 3'b100, err: 1'b1};
`else
      e_tmp = '{cnd: 1'b0, cc: 3'b100, err: 1'b1};
`endif
      drive_beat(2'd2, 64'd0, 1'b1, 1'b1, 4'd3, 1'b1, e_tmp);
      chk("nogap_cnd_valid", {63'd0, bus.cnd_valid}, 64'd1);
      chk("nogap_cnd", {63'd0, bus.cnd}, {63'd0, e_tmp.cnd});
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Illegal code held pending, then reset wins over a simultaneous accept.
      bus.cnd_ready = 1'b0;
      drive_beat(2'd0, 64'd1, 1'b0, 1'b0, 4'd9, 1'b0, '{cnd: 1'b0, cc: 3'b000, err: 1'b0});
      chk("illegal_cnd_valid", {63'd0, bus.cnd_valid}, 64'd1);
      chk("illegal_cnd", {63'd0, bus.cnd}, 64'd0);
      chk("illegal_err", {63'd0, bus.err}, 64'd1);
      rst = 1'b1;
      bus.cnd_ready = 1'b1;
      bus.alu_fun = 2'd0; bus.alu_out = 64'd5; bus.set_cc = 1'b1; bus.ifun = 4'd0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst2_cnd_valid", {63'd0, bus.cnd_valid}, 64'd0);
      chk("rst2_err", {63'd0, bus.err}, 64'd0);
      chk("rst2_cc", {61'd0, bus.cc}, 64'd4);
      chk("rst2_in_ready", {63'd0, bus.in_ready}, 64'd1);
      repeat (2) @(posedge clk);
      #1;

      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cc_eval_unit.md
CC_EVAL_UNIT -- requirements
Module: cc_eval_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning ALU datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream presents an ALU result beat.
REQ-005 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-006 SHALL have port alu_fun  input  2  ALU op: 0 add, 1 sub, 2 and, 3 xor.
REQ-007 SHALL have port alu_out  input  WIDTH  ALU result.
REQ-008 SHALL have port alu_of  input  1  ALU signed-overflow flag.
REQ-009 SHALL have port set_cc  input  1  beat updates condition codes.
REQ-010 SHALL have port ifun  input  4  condition to evaluate: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
REQ-011 SHALL have port cnd_valid  output  1  evaluated condition available.
REQ-012 SHALL have port cnd_ready  input  1  downstream consumes cnd this cycle.
REQ-013 SHALL have port cnd  output  1  condition result.
REQ-014 SHALL have port cc  output  3  registered flags {ZF,SF,OF}.
REQ-015 SHALL have port err  output  1  sticky flag: illegal ifun seen.

Function
REQ-016 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-017 SHALL drive in_ready = !cnd_valid | cnd_ready (single-entry output register; no bubble under full throughput).
REQ-018 SHALL compute new flags from an accepted beat: ZF = (alu_out == 0); SF = alu_out[WIDTH-1]; OF = alu_of for alu_fun 0/1, OF = 0 for alu_fun 2/3.
REQ-019 SHALL load cc with new flags on the edge after acceptance only if set_cc = 1; otherwise cc SHALL hold.
REQ-020 SHALL evaluate le = (SF^OF)|ZF, l = SF^OF, e = ZF, ne = !ZF, ge = !(SF^OF), g = !(SF^OF)&!ZF, always = 1.
REQ-021 SHALL present cnd with cnd_valid = 1 on the edge after acceptance (latency 1 cycle), for every accepted beat.
REQ-022 SHALL hold cnd and cnd_valid stable while cnd_valid = 1 and cnd_ready = 0.
REQ-023 SHALL clear cnd_valid on the edge where cnd_ready = 1 and no new beat is accepted; on simultaneous consume and accept, SHALL replace the result with no gap.
REQ-024 SHALL, for ifun 7..15, output cnd = 0 and set err on that edge; err SHALL stay 1 until reset.
REQ-025 SHALL leave cc unchanged on cycles with no accepted beat, regardless of set_cc.
REQ-026 SHALL ignore all inputs except rst and cnd_ready while in_ready = 0.

Reset
REQ-027 SHALL, on a rising edge with rst = 1, set cc = 3'b100 (ZF=1), cnd = 0, cnd_valid = 0, err = 0, and discard any pending result.
REQ-028 SHALL drive in_ready = 1 in the first cycle after reset; reset SHALL take priority over a simultaneous accept.

Configuration
REQ-029 SHALL support macro CC_EVAL_BYPASS_EN.
REQ-030 With CC_EVAL_BYPASS_EN defined, a beat with set_cc = 1 SHALL evaluate ifun against its own new flags.
REQ-031 Without CC_EVAL_BYPASS_EN, every beat SHALL evaluate ifun against cc as registered before that beat; flag update timing is unchanged.

Verification
REQ-032 Reset then add: alu_fun=0, alu_out=138922938, alu_of=0, set_cc=1, ifun=6 -> next cycle cc=000, cnd_valid=1; cnd=1 with bypass, cnd=0 without (old ZF=1).
REQ-033 Overflow: alu_fun=0, alu_out=0x8000_0000_0000_0000, alu_of=1, set_cc=1, then a second beat with set_cc=0, ifun=2 -> cc=011; second beat cnd=0 (SF^OF=0).
REQ-034 Logic op masks OF: alu_fun=3, alu_of=1, alu_out=0, set_cc=1 -> cc=100; a following beat with ifun=3 gives cnd=1 and ifun=4 gives cnd=0.
REQ-035 Backpressure: accept a beat, hold cnd_ready=0 for 3 cycles -> cnd/cnd_valid stable, in_ready=0; raise cnd_ready with in_valid=1 -> new result the next cycle, no idle cycle.
REQ-036 Illegal ifun=9 -> cnd=0, err=1; err persists across later legal beats; rst=1 while cnd_valid=1 -> cnd_valid=0, err=0, cc=100 next cycle.
